// File: rtl/bus_term_rx.sv
// Bus terminal receiver: destination-filtered FIFO with registered first-word fall-through head.
// Optional destination filtering is compiled in with macro BUS_TERM_RX_ADDR_FILTER_EN.
module bus_term_rx #(
  parameter int         pckg_sz   = 32,
  parameter logic [7:0] broadcast = 8'hFF,
  parameter logic [7:0] id        = 8'h00,
  parameter int         depth     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [pckg_sz-1:0]       D_push,
  input  logic                     pop,
  output logic [pckg_sz-1:0]       D_pop,
  output logic                     pndng,
  output logic                     full,
  output logic [$clog2(depth):0]   count,
  output logic                     ovf,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

`ifdef BUS_TERM_RX_ADDR_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  logic [pckg_sz-1:0] mem [depth];

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [pckg_sz-1:0] dout_q, dout_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        drop_q, drop_d;

  logic [7:0]    dest;
  logic          accept;
  logic          full_w;
  logic          pndng_w;
  logic          rd_en;
  logic          wr_en;
  logic          drop;
  logic [AW-1:0] rd_next;

  assign dest    = D_push[pckg_sz-1 -: 8];
  assign accept  = !FILTER_EN || (dest == id) || (dest == broadcast);
  assign full_w  = (count_q == DEPTH_C);
  assign pndng_w = (count_q != '0);
  assign rd_en   = pop && pndng_w;
  // A pop on a full FIFO frees the slot the push lands in, so the push is kept.
  assign wr_en   = push && accept && (!full_w || rd_en);
  assign drop    = push && accept && full_w && !rd_en;
  assign rd_next = rd_ptr_q + AW'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    ovf_d    = drop;
    drop_d   = drop_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_next;

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Head register: next stored entry, or the incoming packet when it becomes the head.
    if (rd_en) begin
      if (count_q > CW'(1)) dout_d = mem[rd_next];
      else if (wr_en)       dout_d = D_push;
    end else if (wr_en && !pndng_w) begin
      dout_d = D_push;
    end

    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= D_push;
  end

  assign D_pop    = dout_q;
  assign pndng    = pndng_w;
  assign full     = full_w;
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_term_rx.sv
// Directed testbench for bus_term_rx (depth 8, 32-bit packets, id 8'h02).
module tb_bus_term_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic [31:0] D_push;
  logic        pop;
  logic [31:0] D_pop;
  logic        pndng;
  logic        full;
  logic [3:0]  count;
  logic        ovf;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_term_rx #(.pckg_sz(32), .broadcast(8'hFF), .id(8'h02), .depth(8)) dut (
    .clk(clk), .reset(reset), .push(push), .D_push(D_push), .pop(pop),
    .D_pop(D_pop), .pndng(pndng), .full(full), .count(count), .ovf(ovf),
    .drop_cnt(drop_cnt)
  );

  // Apply inputs for one clock edge; outputs are sampled 1 time unit after that edge.
  task automatic step(input logic p, input logic [31:0] d, input logic po);
    push = p; D_push = d; pop = po;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; push = 1'b0; pop = 1'b0; D_push = '0;
    #12;
    total++; if (count !== 4'd0)     begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (pndng !== 1'b0)     begin bad++; $display("FAIL reset_pndng got=%b exp=0", pndng); end
    total++; if (full !== 1'b0)      begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    total++; if (D_pop !== 32'd0)    begin bad++; $display("FAIL reset_dpop got=%h exp=0", D_pop); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_fifo_order();
    logic [31:0] exp_v [3];
    exp_v[0] = 32'h11; exp_v[1] = 32'h22; exp_v[2] = 32'h33;
    step(1'b1, 32'h11, 1'b0);
    total++; if (D_pop !== 32'h11 || pndng !== 1'b1) begin bad++; $display("FAIL order_latency got=%h/%b exp=11/1", D_pop, pndng); end
    step(1'b1, 32'h22, 1'b0);
    step(1'b1, 32'h33, 1'b0);
    total++; if (count !== 4'd3) begin bad++; $display("FAIL order_count got=%0d exp=3", count); end
    for (int i = 0; i < 3; i++) begin
      total++; if (D_pop !== exp_v[i]) begin bad++; $display("FAIL order_data[%0d] got=%h exp=%h", i, D_pop, exp_v[i]); end
      step(1'b0, 32'h0, 1'b1);
    end
    total++; if (pndng !== 1'b0 || count !== 4'd0) begin bad++; $display("FAIL order_empty got=%b/%0d exp=0/0", pndng, count); end
    total++; if (D_pop !== 32'h33) begin bad++; $display("FAIL order_hold got=%h exp=33", D_pop); end
  endtask

  task automatic test_pop_empty();
    step(1'b0, 32'h0, 1'b1);
    total++; if (count !== 4'd0 || pndng !== 1'b0) begin bad++; $display("FAIL pop_empty_count got=%0d/%b exp=0/0", count, pndng); end
    total++; if (D_pop !== 32'h33) begin bad++; $display("FAIL pop_empty_hold got=%h exp=33", D_pop); end
    step(1'b1, 32'h44, 1'b0);
    total++; if (count !== 4'd1 || D_pop !== 32'h44) begin bad++; $display("FAIL pop_empty_after got=%0d/%h exp=1/44", count, D_pop); end
    step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_push_pop_empty();
    step(1'b1, 32'h55, 1'b1);
    total++; if (count !== 4'd1 || D_pop !== 32'h55) begin bad++; $display("FAIL pp_empty got=%0d/%h exp=1/55", count, D_pop); end
    step(1'b1, 32'h66, 1'b1);
    total++; if (count !== 4'd1 || D_pop !== 32'h66) begin bad++; $display("FAIL pp_single got=%0d/%h exp=1/66", count, D_pop); end
    step(1'b0, 32'h0, 1'b1);
    total++; if (pndng !== 1'b0) begin bad++; $display("FAIL pp_drain got=%b exp=0", pndng); end
  endtask

  task automatic test_filter();
`ifdef BUS_TERM_RX_ADDR_FILTER_EN
    step(1'b1, 32'h02000001, 1'b0);
    step(1'b1, 32'h05000002, 1'b0);
    step(1'b1, 32'hFF000003, 1'b0);
    total++; if (count !== 4'd2 || drop_cnt !== 16'd0) begin bad++; $display("FAIL filter_count got=%0d/%0d exp=2/0", count, drop_cnt); end
    total++; if (D_pop !== 32'h02000001) begin bad++; $display("FAIL filter_first got=%h exp=02000001", D_pop); end
    step(1'b0, 32'h0, 1'b1);
    total++; if (D_pop !== 32'hFF000003) begin bad++; $display("FAIL filter_second got=%h exp=FF000003", D_pop); end
    step(1'b0, 32'h0, 1'b1);
`else
    step(1'b1, 32'h05000002, 1'b0);
    total++; if (count !== 4'd1 || D_pop !== 32'h05000002) begin bad++; $display("FAIL nofilter got=%0d/%h exp=1/05000002", count, D_pop); end
    step(1'b0, 32'h0, 1'b1);
`endif
    total++; if (count !== 4'd0) begin bad++; $display("FAIL filter_drain got=%0d exp=0", count); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) step(1'b1, 32'h100 + i, 1'b0);
    total++; if (full !== 1'b1 || count !== 4'd8) begin bad++; $display("FAIL ovf_fill got=%b/%0d exp=1/8", full, count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", ovf); end
    step(1'b1, 32'h00ABCDEF, 1'b0);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b exp=1", ovf); end
    total++; if (drop_cnt !== 16'd1 || count !== 4'd8) begin bad++; $display("FAIL ovf_drop got=%0d/%0d exp=1/8", drop_cnt, count); end
    step(1'b0, 32'h0, 1'b0);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_width got=%b exp=0", ovf); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_q [$];
    for (int i = 1; i < 8; i++) exp_q.push_back(32'h100 + i);
    exp_q.push_back(32'h99);
    total++; if (D_pop !== 32'h100) begin bad++; $display("FAIL fpp_head got=%h exp=100", D_pop); end
    step(1'b1, 32'h99, 1'b1);
    total++; if (count !== 4'd8 || ovf !== 1'b0 || drop_cnt !== 16'd1) begin bad++; $display("FAIL fpp_state got=%0d/%b/%0d exp=8/0/1", count, ovf, drop_cnt); end
    for (int i = 0; i < 8; i++) begin
      total++; if (D_pop !== exp_q[i]) begin bad++; $display("FAIL fpp_data[%0d] got=%h exp=%h", i, D_pop, exp_q[i]); end
      step(1'b0, 32'h0, 1'b1);
    end
    total++; if (pndng !== 1'b0) begin bad++; $display("FAIL fpp_empty got=%b exp=0", pndng); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_q [$];
    logic        do_pop;
    int          reads = 0;
    for (int i = 0; i < 20; i++) begin
      do_pop = (exp_q.size() >= 3);
      if (do_pop) begin
        total++; if (D_pop !== exp_q[0]) begin bad++; $display("FAIL wrap_data[%0d] got=%h exp=%h", reads, D_pop, exp_q[0]); end
        void'(exp_q.pop_front());
        reads++;
      end
      step(1'b1, 32'hA000 + i, do_pop);
      exp_q.push_back(32'hA000 + i);
    end
    while (exp_q.size() > 0) begin
      total++; if (D_pop !== exp_q[0]) begin bad++; $display("FAIL wrap_data[%0d] got=%h exp=%h", reads, D_pop, exp_q[0]); end
      void'(exp_q.pop_front());
      reads++;
      step(1'b0, 32'h0, 1'b1);
    end
    total++; if (reads != 20 || count !== 4'd0) begin bad++; $display("FAIL wrap_total got=%0d/%0d exp=20/0", reads, count); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h200 + i, 1'b0);
    total++; if (count !== 4'd4) begin bad++; $display("FAIL areset_pre got=%0d exp=4", count); end
    #2 reset = 1'b0;
    #1;
    total++; if (pndng !== 1'b0 || count !== 4'd0 || ovf !== 1'b0) begin bad++; $display("FAIL areset_now got=%b/%0d/%b exp=0/0/0", pndng, count, ovf); end
    total++; if (drop_cnt !== 16'd0 || D_pop !== 32'd0) begin bad++; $display("FAIL areset_regs got=%0d/%h exp=0/0", drop_cnt, D_pop); end
    #1 reset = 1'b1;
    step(1'b1, 32'h77, 1'b0);
    total++; if (count !== 4'd1 || D_pop !== 32'h77) begin bad++; $display("FAIL areset_push got=%0d/%h exp=1/77", count, D_pop); end
    step(1'b0, 32'h0, 1'b1);
    total++; if (pndng !== 1'b0) begin bad++; $display("FAIL areset_only got=%b exp=0", pndng); end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_pop_empty();
    test_push_pop_empty();
    test_filter();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
